// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared types and constants for the program-counter unit:
//             next-PC select encoding, instruction size and the alignment
//             mask applied to redirect and trap targets.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Source of the next fetch address.
  typedef enum logic [2:0] {
    PC_SEQ      = 3'd0,
    PC_RAS      = 3'd1,
    PC_REDIRECT = 3'd2,
    PC_TRAP     = 3'd3,
    PC_HOLD     = 3'd4
  } pc_sel_e;

  localparam int         INSTR_BYTES = 4;
  // Low address bits that must be zero for a legal fetch address.
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |(low_bits & ALIGN_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_unit_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ras_stack
//  Purpose  : Circular return-address stack. A push beyond RAS_DEPTH
//             overwrites the oldest entry; the count saturates.
//  Ports    : clk, reset (async, active-high)
//             push/pop/clear   - operation requests for this cycle
//             push_data        - address to push
//             top              - most recently pushed entry (comb. read)
//             count            - number of valid entries
//  Revision : 1.0 - initial release
// ============================================================================
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [XLEN-1:0]                push_data,
  output logic [XLEN-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;      // next free slot; top lives at ptr_q-1
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] top_idx, wr_idx;
  logic             wr_en;
  logic             nonempty;

  assign top_idx  = ptr_q - PTR_W'(1);
  assign nonempty = (count_q != '0);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push && pop && nonempty) begin
      // Return immediately followed by a call: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      // Also covers a pop on an empty stack paired with a push: nothing to
      // pop, so the push proceeds normally. Pointer wraps naturally.
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q != C_FULL) count_d = count_q + CNT_W'(1);
    end else if (pop && nonempty) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

  assign top   = mem_q[top_idx];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program counter with next-PC priority mux
//             (trap > redirect > stall > return > sequential) and a
//             return-address stack for call/return prediction.
//  Ports    : clk, reset (async, active-high), stall
//             redirect_valid/redirect_target - taken branch or jump
//             trap_valid/trap_vector         - trap entry
//             call_push/ret_pop              - call/return hints
//             pc_current (reg), pc_plus4 (comb), ras_count (reg)
//             redirect_misaligned, ras_underflow - registered 1-cycle pulses
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_target,
  input  logic                           trap_valid,
  input  logic [XLEN-1:0]                trap_vector,
  input  logic                           call_push,
  input  logic                           ret_pop,
  output logic [XLEN-1:0]                pc_current,
  output logic [XLEN-1:0]                pc_plus4,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           redirect_misaligned,
  output logic                           ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic             underflow_q, underflow_d;
  pc_sel_e          sel;
  logic             ras_push, ras_pop, ras_clear;
  logic [XLEN-1:0]  ras_top;
  logic [CNT_W-1:0] ras_cnt;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  // Priority decode: choose the next-PC source and the RAS operation.
  always_comb begin
    sel          = PC_SEQ;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_clear    = 1'b0;
    misaligned_d = 1'b0;
    underflow_d  = 1'b0;
    if (trap_valid) begin
      sel       = PC_TRAP;
      ras_clear = 1'b1;
    end else if (redirect_valid) begin
      sel          = PC_REDIRECT;
      ras_push     = call_push;
      misaligned_d = is_misaligned(redirect_target[1:0]);
    end else if (stall) begin
      sel = PC_HOLD;
    end else begin
      ras_push = call_push;
      if (ret_pop) begin
        ras_pop = 1'b1;
        if (ras_cnt != '0) begin
          sel = PC_RAS;
        end else begin
          sel         = PC_SEQ;
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc_d = pc_plus4;
    case (sel)
      PC_TRAP:     pc_d = {trap_vector[XLEN-1:2], 2'b00};
      PC_REDIRECT: pc_d = {redirect_target[XLEN-1:2], 2'b00};
      PC_HOLD:     pc_d = pc_q;
      PC_RAS:      pc_d = ras_top;
      default:     pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      underflow_q  <= underflow_d;
    end
  end

  assign pc_current          = pc_q;
  assign ras_count           = ras_cnt;
  assign redirect_misaligned = misaligned_q;
  assign ras_underflow       = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit
//             (RESET_VECTOR = 0x100, RAS_DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        call_push;
  logic        ret_pop;
  logic [31:0] pc_current;
  logic [31:0] pc_plus4;
  logic [2:0]  ras_count;
  logic        redirect_misaligned;
  logic        ras_underflow;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .trap_valid          (trap_valid),
    .trap_vector         (trap_vector),
    .call_push           (call_push),
    .ret_pop             (ret_pop),
    .pc_current          (pc_current),
    .pc_plus4            (pc_plus4),
    .ras_count           (ras_count),
    .redirect_misaligned (redirect_misaligned),
    .ras_underflow       (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    call_push       = 1'b0;
    ret_pop         = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if (pc_current !== 32'h100) begin
      tests_failed++;
      $display("FAIL reset_pc: got %h expected %h", pc_current, 32'h100);
    end
    tests_run++;
    if (ras_count !== 3'd0 || redirect_misaligned !== 1'b0 || ras_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got cnt=%0d mis=%b unf=%b expected 0 0 0",
               ras_count, redirect_misaligned, ras_underflow);
    end
    reset = 1'b0;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      tests_run++;
      if (pc_current !== exp_pc || ras_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL idle_seq[%0d]: got pc=%h cnt=%0d expected pc=%h cnt=0",
                 i, pc_current, ras_count, exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    step();
    idle_inputs();
    stall   = 1'b1;
    ret_pop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (pc_current !== 32'h20 || ras_count !== 3'd0 || ras_underflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got pc=%h cnt=%0d unf=%b expected pc=00000020 cnt=0 unf=0",
                 i, pc_current, ras_count, ras_underflow);
      end
    end
    idle_inputs();
  endtask

  task automatic test_redirect_misaligned();
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'h40 || redirect_misaligned !== 1'b1) begin
      tests_failed++;
      $display("FAIL redirect_mis: got pc=%h mis=%b expected pc=00000040 mis=1",
               pc_current, redirect_misaligned);
    end
    step();
    tests_run++;
    if (pc_current !== 32'h44 || redirect_misaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_mis_clear: got pc=%h mis=%b expected pc=00000044 mis=0",
               pc_current, redirect_misaligned);
    end
  endtask

  task automatic test_ras_sequence();
    logic [31:0] tgt [5];
    logic [31:0] ret [4];
    logic [2:0]  exp_cnt [5];
    tgt = '{32'h30, 32'h50, 32'h70, 32'h90, 32'hB0};
    ret = '{32'h94, 32'h74, 32'h54, 32'h34};
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    step();
    for (int i = 0; i < 5; i++) begin
      redirect_valid  = 1'b1;
      redirect_target = tgt[i];
      call_push       = 1'b1;
      step();
      tests_run++;
      if (pc_current !== tgt[i] || ras_count !== exp_cnt[i]) begin
        tests_failed++;
        $display("FAIL call[%0d]: got pc=%h cnt=%0d expected pc=%h cnt=%0d",
                 i, pc_current, ras_count, tgt[i], exp_cnt[i]);
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ret_pop = 1'b1;
      step();
      tests_run++;
      if (pc_current !== ret[i] || ras_count !== 3'(3 - i) || ras_underflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL return[%0d]: got pc=%h cnt=%0d unf=%b expected pc=%h cnt=%0d unf=0",
                 i, pc_current, ras_count, ras_underflow, ret[i], 3 - i);
      end
    end
    step();
    tests_run++;
    if (pc_current !== 32'h38 || ras_count !== 3'd0 || ras_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow: got pc=%h cnt=%0d unf=%b expected pc=00000038 cnt=0 unf=1",
               pc_current, ras_count, ras_underflow);
    end
    idle_inputs();
    step();
    tests_run++;
    if (pc_current !== 32'h3C || ras_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_clear: got pc=%h unf=%b expected pc=0000003c unf=0",
               pc_current, ras_underflow);
    end
  endtask

  task automatic test_trap();
    redirect_valid  = 1'b1;
    call_push       = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect_target = 32'h300;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'h300 || ras_count !== 3'd2) begin
      tests_failed++;
      $display("FAIL trap_setup: got pc=%h cnt=%0d expected pc=00000300 cnt=2",
               pc_current, ras_count);
    end
    trap_valid  = 1'b1;
    trap_vector = 32'h803;
    call_push   = 1'b1;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'h800 || ras_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL trap: got pc=%h cnt=%0d expected pc=00000800 cnt=0",
               pc_current, ras_count);
    end
  endtask

  task automatic test_push_pop_same();
    redirect_valid  = 1'b1;
    redirect_target = 32'h900;
    call_push       = 1'b1;
    step();
    idle_inputs();
    call_push = 1'b1;
    ret_pop   = 1'b1;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'h804 || ras_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL push_pop: got pc=%h cnt=%0d expected pc=00000804 cnt=1",
               pc_current, ras_count);
    end
    ret_pop = 1'b1;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'h904 || ras_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL push_pop_top: got pc=%h cnt=%0d expected pc=00000904 cnt=0",
               pc_current, ras_count);
    end
  endtask

  task automatic test_async_reset_and_wrap();
    redirect_valid  = 1'b1;
    redirect_target = 32'h1C;
    call_push       = 1'b1;
    step();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (pc_current !== 32'h100 || ras_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got pc=%h cnt=%0d expected pc=00000100 cnt=0",
               pc_current, ras_count);
    end
    #1;
    reset = 1'b0;
    step();
    tests_run++;
    if (pc_current !== 32'h104) begin
      tests_failed++;
      $display("FAIL post_reset: got pc=%h expected pc=00000104", pc_current);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    tests_run++;
    if (pc_current !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_setup: got pc=%h plus4=%h expected pc=fffffffc plus4=00000000",
               pc_current, pc_plus4);
    end
    step();
    tests_run++;
    if (pc_current !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap: got pc=%h expected pc=00000000", pc_current);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_misaligned();
    test_ras_sequence();
    test_trap();
    test_push_pop_same();
    test_async_reset_and_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
